// File: rtl/top_pkg.sv
// Shared types and codes for the framed-word link endpoint.
package top_pkg;
  localparam logic [1:0]  TYPE_SOF      = 2'b01;
  localparam logic [1:0]  TYPE_BODY     = 2'b00;
  localparam logic [1:0]  TYPE_EOF      = 2'b10;
  localparam logic [1:0]  CTRL_IDLE     = 2'b11;
  localparam logic [31:0] DEF_IDLE_WORD = 32'hBCBCBCBC;

  typedef enum logic {RX_IDLE, RX_IN_FRAME} rx_state_e;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [31:0] data;
  } lane_word_t;
endpackage

// File: rtl/link_fifo.sv
// Synchronous FIFO; a full FIFO accepts a write in the same edge as a read.
module link_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr, rptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_rd, do_wr;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/top.sv
// Framed-word link endpoint: tx FIFO onto lane, rx lock, delivery and frame check.
// Define INTERNAL_LOOPBACK_EN to feed the receiver from the registered tx lane.
module top
  import top_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          LOCK_COUNT = 16,
  parameter logic [31:0] IDLE_WORD  = DEF_IDLE_WORD
) (
  input  logic        write_clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] din,
  input  logic [1:0]  dtin,
  input  logic        link_ready,
  output logic [31:0] tx_data,
  output logic [1:0]  tx_ctrl,
  input  logic [31:0] rx_data,
  input  logic [1:0]  rx_ctrl,
  output logic        rxinit_done,
  output logic [31:0] dout,
  output logic [1:0]  dtout,
  output logic        dvalid,
  output logic        frame_err,
  output logic        overflow,
  output logic [15:0] frame_cnt
);
  localparam int             LW       = $clog2(LOCK_COUNT + 1);
  localparam logic [LW-1:0]  LOCK_MAX = LW'(LOCK_COUNT);

  lane_word_t wr_word, head, rx_w;
  logic       full, empty, pop;
  logic [LW-1:0] lock_cnt;
  rx_state_e  state;

  assign wr_word = '{ctrl: dtin, data: din};
  assign pop     = link_ready & ~empty;

  link_fifo #(.W($bits(lane_word_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (write_clk),
    .rst    (rst),
    .wr_en  (we),
    .wr_data(wr_word),
    .rd_en  (pop),
    .rd_data(head),
    .full   (full),
    .empty  (empty)
  );

`ifdef INTERNAL_LOOPBACK_EN
  assign rx_w = '{ctrl: tx_ctrl, data: tx_data};
`else
  assign rx_w = '{ctrl: rx_ctrl, data: rx_data};
`endif

  always_ff @(posedge write_clk) begin
    if (rst) begin
      tx_data  <= IDLE_WORD;
      tx_ctrl  <= CTRL_IDLE;
      overflow <= 1'b0;
    end else begin
      tx_data <= pop ? head.data : IDLE_WORD;
      tx_ctrl <= pop ? head.ctrl : CTRL_IDLE;
      if (we && full && !pop) overflow <= 1'b1;
    end
  end

  // Once locked the counter no longer matters; rxinit_done is sticky until rst.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      lock_cnt    <= '0;
      rxinit_done <= 1'b0;
    end else begin
      if (lock_cnt == LOCK_MAX) rxinit_done <= 1'b1;
      if (rx_w.ctrl == CTRL_IDLE) begin
        if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
      end else if (!rxinit_done) begin
        lock_cnt <= '0;
      end
    end
  end

  always_ff @(posedge write_clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      dout      <= '0;
      dtout     <= '0;
      dvalid    <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      dvalid    <= 1'b0;
      frame_err <= 1'b0;
      if (rxinit_done && rx_w.ctrl != CTRL_IDLE) begin
        dvalid <= 1'b1;
        dout   <= rx_w.data;
        dtout  <= rx_w.ctrl;
        case (state)
          RX_IDLE: begin
            if (rx_w.ctrl == TYPE_SOF) state <= RX_IN_FRAME;
            else                       frame_err <= 1'b1;
          end
          RX_IN_FRAME: begin
            if (rx_w.ctrl == TYPE_SOF) begin
              frame_err <= 1'b1;
            end else if (rx_w.ctrl == TYPE_EOF) begin
              state     <= RX_IDLE;
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_top.sv
// Directed + random bench for top with an external lane loopback and a queue-based model.
module tb_top;
  import top_pkg::*;

  localparam int DEPTH = 16;
  localparam int LOCK  = 16;

  logic        write_clk = 1'b0;
  logic        rst, we, link_ready;
  logic [31:0] din;
  logic [1:0]  dtin;
  logic [31:0] tx_data, rx_data, dout;
  logic [1:0]  tx_ctrl, rx_ctrl, dtout;
  logic        rxinit_done, dvalid, frame_err, overflow;
  logic [15:0] frame_cnt;

  assign rx_data = tx_data;
  assign rx_ctrl = tx_ctrl;

  top dut (
    .write_clk(write_clk), .rst(rst), .we(we), .din(din), .dtin(dtin),
    .link_ready(link_ready), .tx_data(tx_data), .tx_ctrl(tx_ctrl),
    .rx_data(rx_data), .rx_ctrl(rx_ctrl), .rxinit_done(rxinit_done),
    .dout(dout), .dtout(dtout), .dvalid(dvalid), .frame_err(frame_err),
    .overflow(overflow), .frame_cnt(frame_cnt)
  );

  always #5 write_clk = ~write_clk;

  // model state
  logic [33:0] mq[$];
  logic [31:0] m_ld, m_dout;
  logic [1:0]  m_lc, m_dt;
  int          m_cnt;
  bit          m_lock, m_inf, m_dv, m_err, m_ovf;
  logic [15:0] m_fc;

  int tests = 0, fails = 0, dv_seen = 0, err_seen = 0, lock_at;
  logic [31:0] fw[8];
  logic [1:0]  ft[8];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit nl, pop_now;
    logic [33:0] w;
    if (rst) begin
      mq.delete();
      m_ld = DEF_IDLE_WORD; m_lc = 2'b11; m_cnt = 0; m_lock = 0; m_inf = 0;
      m_dv = 0; m_err = 0; m_ovf = 0; m_dout = '0; m_dt = '0; m_fc = '0;
    end else begin
      nl = m_lock || (m_cnt == LOCK);
      m_dv = 0; m_err = 0;
      if (m_lock && m_lc != 2'b11) begin
        m_dv = 1; m_dout = m_ld; m_dt = m_lc;
        case (m_lc)
          2'b01: begin m_err = m_inf; m_inf = 1; end
          2'b00: m_err = !m_inf;
          default: if (m_inf) begin m_fc++; m_inf = 0; end else m_err = 1;
        endcase
      end
      if (m_lc == 2'b11) begin
        if (m_cnt < LOCK) m_cnt++;
      end else if (!m_lock) m_cnt = 0;
      m_lock = nl;
      pop_now = link_ready && mq.size() > 0;
      if (pop_now) begin
        w = mq.pop_front(); m_ld = w[31:0]; m_lc = w[33:32];
      end else begin
        m_ld = DEF_IDLE_WORD; m_lc = 2'b11;
      end
      if (we) begin
        if (mq.size() < DEPTH) mq.push_back({dtin, din});
        else m_ovf = 1;
      end
    end
  endtask

  task automatic step(input bit w, input logic [31:0] d, input logic [1:0] t, input bit lr);
    we = w; din = d; dtin = t; link_ready = lr;
    @(posedge write_clk);
    model_edge();
    #1;
    if (dvalid) dv_seen++;
    if (frame_err) err_seen++;
    check("tx_data", tx_data, m_ld);
    check("tx_ctrl", tx_ctrl, m_lc);
    check("rxinit_done", rxinit_done, m_lock);
    check("dvalid", dvalid, m_dv);
    check("dout", dout, m_dout);
    check("dtout", dtout, m_dt);
    check("frame_err", frame_err, m_err);
    check("overflow", overflow, m_ovf);
    check("frame_cnt", frame_cnt, m_fc);
  endtask

  task automatic idle(input int n, input bit lr);
    repeat (n) step(0, 32'h0, 2'b00, lr);
  endtask

  task automatic send_frame(input bit lr);
    for (int i = 0; i < 8; i++) step(1, fw[i], ft[i], lr);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_data"}, tx_data, 32'hBCBCBCBC);
    check({tag, "_tx_ctrl"}, tx_ctrl, 2'b11);
    check({tag, "_rxinit"}, rxinit_done, 1'b0);
    check({tag, "_dvalid"}, dvalid, 1'b0);
    check({tag, "_dout"}, dout, 32'h0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_fcnt"}, frame_cnt, 16'h0);
  endtask

  task automatic wait_lock(input string tag);
    lock_at = 0;
    for (int i = 1; i <= 40 && lock_at == 0; i++) begin
      step(0, 32'h0, 2'b00, 0);
      if (rxinit_done) lock_at = i;
    end
    check(tag, lock_at, 17);
  endtask

  initial begin
    fw = '{32'h12345678, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4,
           32'hD1D2D3D4, 32'hE1E2E3E4, 32'hF1F2F3F4, 32'hABCDEF12};
    ft = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    rst = 1; we = 0; din = 0; dtin = 0; link_ready = 0;

    repeat (3) step(0, 32'h0, 2'b00, 0);
    check_reset_vals("reset");
    rst = 0;
    wait_lock("lock_latency");
    check("no_dv_before_lock", dv_seen, 0);

    dv_seen = 0; err_seen = 0;
    send_frame(1); idle(6, 1);
    check("frame1_dv", dv_seen, 8);
    check("frame1_cnt", frame_cnt, 1);
    check("frame1_err", err_seen, 0);

    idle(1500, 1);
    dv_seen = 0;
    send_frame(1); idle(6, 1);
    check("frame2_dv", dv_seen, 8);
    check("frame2_cnt", frame_cnt, 2);

    dv_seen = 0;
    send_frame(0); idle(5, 0);
    check("buffered_no_dv", dv_seen, 0);
    idle(12, 1);
    check("buffered_dv", dv_seen, 8);
    check("buffered_cnt", frame_cnt, 3);

    dv_seen = 0;
    for (int i = 0; i < 17; i++)
      step(1, 32'h5000_0000 + i, (i == 0) ? 2'b01 : (i == 16) ? 2'b10 : 2'b00, 0);
    check("overflow_set", overflow, 1'b1);
    idle(22, 1);
    check("overflow_dv", dv_seen, 16);
    check("overflow_cnt", frame_cnt, 3);
    step(1, 32'hE0F0E0F0, 2'b10, 1); idle(4, 1);
    check("close_cnt", frame_cnt, 4);

    dv_seen = 0; err_seen = 0;
    step(1, 32'hA1A2A3A4, 2'b00, 1); idle(4, 1);
    check("nosof_dv", dv_seen, 1);
    check("nosof_err", err_seen, 1);
    check("nosof_dtout", dtout, 2'b00);
    check("nosof_cnt", frame_cnt, 4);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) == 1, $urandom, 2'($urandom_range(0, 3)),
           $urandom_range(0, 3) != 0);
    idle(30, 1);

    step(1, 32'h0101_0101, 2'b01, 1);
    step(1, 32'h0202_0202, 2'b00, 1);
    step(1, 32'h0303_0303, 2'b00, 1);
    rst = 1;
    step(1, 32'h0404_0404, 2'b00, 1);
    check_reset_vals("midrst");
    rst = 0;
    wait_lock("relock_latency");
    dv_seen = 0;
    send_frame(1); idle(6, 1);
    check("after_rst_dv", dv_seen, 8);
    check("after_rst_cnt", frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/top.md
Name: top

Overview:
- Single-clock framed-word link endpoint for the full-mode receiver path.
- Transmit side: buffers 32-bit words tagged with a 2-bit frame type in a FIFO and drains them onto a parallel lane (data + control). While empty or not enabled, it sends idle words.
- Receive side: acquires lock on consecutive idles, then delivers received words with their type and checks frame ordering.
- Lane pins are looped back externally at top level (or internally with the optional feature).

Parameters:
- FIFO_DEPTH, 16: transmit FIFO entries; must be a power of two, at least 2.
- LOCK_COUNT, 16: consecutive idle words needed to assert rxinit_done.
- IDLE_WORD, 32'hBCBCBCBC: data value sent with idle control code.

Ports:
- write_clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write strobe; pushes din/dtin when FIFO not full.
- din  in  32  payload word.
- dtin  in  2  type: 01 start-of-frame (SOF), 00 body, 10 end-of-frame (EOF), 11 reserved.
- link_ready  in  1  enables FIFO draining onto the lane.
- tx_data  out  32  lane data.
- tx_ctrl  out  2  lane control: word type, or 11 = idle.
- rx_data  in  32  received lane data.
- rx_ctrl  in  2  received lane control.
- rxinit_done  out  1  receiver locked.
- dout  out  32  received payload.
- dtout  out  2  received type.
- dvalid  out  1  dout/dtout valid, one-cycle pulse per word.
- frame_err  out  1  one-cycle pulse on frame-order violation.
- overflow  out  1  sticky; a write was attempted while the FIFO was full.
- frame_cnt  out  16  count of completed good frames; wraps.

Behaviour:
- Reset values:
  - tx_data = IDLE_WORD, tx_ctrl = 11.
  - FIFO empty; rxinit_done = 0; dout = 0; dtout = 0.
  - dvalid, frame_err, overflow = 0; frame_cnt = 0.
  - Receiver state IDLE, lock counter 0.
- Reset mid-operation discards FIFO contents and any frame in progress.
- FIFO write:
  - On an edge with we = 1 and not full, store {dtin, din}.
  - we while full: drop the word and set overflow (cleared only by rst).
  - dtin = 11 writes are stored and sent as-is; the receiver ignores them as idle.
- Simultaneous push and pop when full is allowed (pop frees the slot in the same edge); when empty, the pushed word is not popped in that cycle.
- Transmit:
  - Each edge with link_ready = 1 and FIFO non-empty: pop the head into tx_data/tx_ctrl.
  - Otherwise load IDLE_WORD/11.
  - A word written at edge t is on the lane after edge t+1 at the earliest; one word per cycle.
  - Writes while link_ready = 0 are buffered and drained after link_ready rises.
  - Deasserting link_ready mid-frame inserts idles; the frame is not aborted.
- Receive lock:
  - Counter increments on each cycle with rx_ctrl = 11 and saturates at LOCK_COUNT.
  - A non-idle control resets it to 0 while unlocked.
  - rxinit_done rises the cycle after the count reaches LOCK_COUNT and stays high until rst.
- Receive data (only when rxinit_done = 1):
  - rx_ctrl != 11 registers dout = rx_data, dtout = rx_ctrl, dvalid = 1 on the next edge (latency 1).
  - Idles are ignored, including inside a frame.
- Frame checker, states IDLE and IN_FRAME:
  - IDLE + SOF -> IN_FRAME.
  - IN_FRAME + body -> stay.
  - IN_FRAME + EOF -> IDLE, and frame_cnt increments in the same edge dvalid asserts.
  - IDLE + body or EOF -> frame_err pulse, stay IDLE.
  - IN_FRAME + SOF -> frame_err pulse, restart (stay IN_FRAME, new frame).
  - Errored words are still delivered with dvalid.

Optional Feature:
- INTERNAL_LOOPBACK_EN
  - Defined: the receiver uses the registered tx_data/tx_ctrl internally and ignores rx_data/rx_ctrl. Lock and data timing are unchanged relative to the internal lane.
  - Undefined: the receiver uses the rx_data/rx_ctrl pins.

Decomposition:
- Shared package top_pkg holds:
  - type codes TYPE_SOF = 01, TYPE_BODY = 00, TYPE_EOF = 10, CTRL_IDLE = 11;
  - default IDLE_WORD;
  - the receiver state enum.
- One natural sub-module: link_fifo, a synchronous FIFO with full/empty, width 34.

Test Plan:
- Reset, pins looped back, link_ready = 0 -> lane carries BCBCBCBC/11; rxinit_done rises 17 cycles after reset release; no dvalid.
- After lock, link_ready = 1, write frame 12345678/01, A1A2A3A4 … F1F2F3F4/00, ABCDEF12/10 on consecutive cycles -> dvalid for 8 consecutive cycles with identical words/types; frame_cnt = 1; frame_err never pulses.
- Same frame again after 1500 idle cycles -> identical output; frame_cnt = 2.
- Write the 8-word frame with link_ready = 0, then raise it -> all 8 words delivered in order after the rise.
- link_ready = 0, 17 writes with FIFO_DEPTH = 16 -> overflow = 1; first 16 words delivered, 17th absent.
- After lock, send A1A2A3A4/00 with no SOF -> dvalid with dtout = 00 plus a frame_err pulse; frame_cnt unchanged.
- Assert rst mid-frame -> all outputs return to reset values; lock must be reacquired.
